sevenseg_bus_decoder: RTL and testbench

- Passive reader on the multiplexed seven-segment display bus: segment lines plus digit anodes, all active-low.
- Waits until the bus is stable with exactly one anode driven, then decodes the segment pattern back to a 4-bit hex value and stores it per digit.
- Instantiated in the top level alongside the display driver for self-check and score readback.
- Flags illegal patterns and multi-anode conditions.

---
 rtl/sevenseg_bus_decoder.sv | 154 +++++++++++++++
 tb/tb_sevenseg_bus_decoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_bus_decoder.sv
// Passive reader for a multiplexed active-low seven-segment bus: waits for a steady
// single-anode phase, decodes the segments back to hex and keeps one value per digit.
module sevenseg_bus_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int NDIG          = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg,
    input  logic [NDIG-1:0]     an,
    input  logic                clr_err,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     digit_valid,
    output logic                frame_done,
    output logic                err
);

    typedef enum logic [1:0] {S_WAIT, S_ARM, S_HOLD} state_t;

    localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

    state_t              state_q, state_d;
    logic [6:0]          seg_q;
    logic [NDIG-1:0]     an_q;
    logic [7:0]          cnt_q, cnt_d;
    logic [4*NDIG-1:0]   digits_q, digits_d;
    logic [NDIG-1:0]     valid_q, valid_d;
    logic [NDIG-1:0]     seen_q, seen_d;
    logic                fd_q, fd_d;
    logic                err_q, err_d;

    logic                chg;
    logic                cap_edge;
    logic [NDIG-1:0]     an_low;
    logic                blank;
    logic                one_hot;
    logic [4:0]          dec;
    logic [NDIG-1:0]     dig_upd;

    // Returns {legal, value} for an active-high g..a segment pattern.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0111111: decode = 5'h10;
            7'b0000110: decode = 5'h11;
            7'b1011011: decode = 5'h12;
            7'b1001111: decode = 5'h13;
            7'b1100110: decode = 5'h14;
            7'b1101101: decode = 5'h15;
            7'b1111101: decode = 5'h16;
            7'b0000111: decode = 5'h17;
            7'b1111111: decode = 5'h18;
            7'b1101111: decode = 5'h19;
            7'b1110111: decode = 5'h1A;
            7'b1111100: decode = 5'h1B;
            7'b0111001: decode = 5'h1C;
            7'b1011110: decode = 5'h1D;
            7'b1111001: decode = 5'h1E;
            7'b1110001: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

    // The incoming sample is compared with the held one, so the capture lands on
    // the (STABLE_CYCLES+1)th edge counting the edge that registers the new bus.
    assign chg      = {seg, an} != {seg_q, an_q};
    assign cap_edge = !chg && (cnt_q == STABLE_W - 8'd1);
    assign an_low   = ~an_q;
    assign blank    = (an_low == '0);
    assign one_hot  = !blank && ((an_low & (an_low - 1'b1)) == '0);
    assign dec      = decode(~seg_q);

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_upd
        assign dig_upd[gi] = one_hot && an_low[gi];
    end

    always_comb begin
        cnt_d = cnt_q;
        if (chg)
            cnt_d = 8'd0;
        else if (cnt_q < STABLE_W)
            cnt_d = cnt_q + 8'd1;
    end

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        valid_d  = valid_q;
        seen_d   = seen_q;
        fd_d     = 1'b0;
        err_d    = err_q & ~clr_err;
        case (state_q)
            S_WAIT: if (chg) state_d = S_ARM;
            S_ARM: begin
                if (cap_edge) begin
                    if (blank) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_HOLD;
                        if (!one_hot)
                            err_d = 1'b1;
                        for (int i = 0; i < NDIG; i++) begin
                            if (dig_upd[i]) begin
                                seen_d[i] = 1'b1;
                                if (dec[4]) begin
                                    digits_d[4*i +: 4] = dec[3:0];
                                    valid_d[i]         = 1'b1;
                                end else begin
                                    valid_d[i] = 1'b0;
                                    err_d      = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            S_HOLD: if (chg) state_d = S_ARM;
            default: state_d = S_WAIT;
        endcase
        if (&seen_d) begin
            fd_d   = 1'b1;
            seen_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_WAIT;
            seg_q    <= '1;
            an_q     <= '1;
            cnt_q    <= 8'd0;
            digits_q <= '0;
            valid_q  <= '0;
            seen_q   <= '0;
            fd_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            seg_q    <= seg;
            an_q     <= an;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            seen_q   <= seen_d;
            fd_q     <= fd_d;
            err_q    <= err_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign frame_done  = fd_q;
    assign err         = err_q;

endmodule

// File: tb/tb_sevenseg_bus_decoder.sv
// Scoreboard bench for sevenseg_bus_decoder: each bus phase pushes the expected
// register state for the cycles around its capture edge; a negedge monitor compares.
module tb_sevenseg_bus_decoder;

    localparam int SC   = 4;
    localparam int NDIG = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr_err = 1'b0;
    logic [6:0]        seg = 7'h7F;
    logic [NDIG-1:0]   an  = 4'hF;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   digit_valid;
    logic              frame_done;
    logic              err;

    sevenseg_bus_decoder #(.STABLE_CYCLES(SC), .NDIG(NDIG)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .clr_err     (clr_err),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int          cyc;
        logic [15:0] dig;
        logic [3:0]  val;
        logic        er;
        logic        fd;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];

    int n_cmp  = 0;
    int n_bad  = 0;
    int fd_cnt = 0;
    int base   = 0;

    logic [15:0] cur_dig = '0;
    logic [3:0]  cur_val = '0;
    logic        cur_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input int c, input logic [15:0] d, input logic [3:0] v,
                        input logic e, input logic f, input string tag);
        exp_t x;
        x.cyc = c;
        x.dig = d;
        x.val = v;
        x.er  = e;
        x.fd  = f;
        sb.push_back(x);
        sb_tag.push_back(tag);
    endtask

    // Holds one bus state for len edges; pat is the logical g..a pattern.
    task automatic phase(input string tag, input logic [6:0] pat, input logic [3:0] a,
                         input int len, input bit cap, input logic [15:0] d,
                         input logic [3:0] v, input logic e, input logic f);
        int s;
        seg = ~pat;
        an  = a;
        s   = cyc;
        if (cap) begin
            push(s + SC,     cur_dig, cur_val, cur_err, 1'b0, {tag, "-pre"});
            push(s + SC + 1, d, v, e, f, tag);
            push(s + SC + 2, d, v, e, 1'b0, {tag, "-post"});
            cur_dig = d;
            cur_val = v;
            cur_err = e;
        end else begin
            push(s + len, cur_dig, cur_val, cur_err, 1'b0, tag);
        end
        repeat (len) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon
        exp_t  x;
        string t;
        if (frame_done === 1'b1)
            fd_cnt++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            x = sb.pop_front();
            t = sb_tag.pop_front();
            chk({t, "/cyc"}, cyc, x.cyc);
            chk({t, "/digits"}, digits, x.dig);
            chk({t, "/valid"}, digit_valid, x.val);
            chk({t, "/err"}, err, x.er);
            chk({t, "/frame_done"}, frame_done, x.fd);
            $display("txn %-10s cyc=%0d digits=%h valid=%h err=%b fd=%b", t, cyc,
                     digits, digit_valid, err, frame_done);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_digits", digits, 0);
        chk("rst_valid", digit_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_fd", frame_done, 0);
        rst = 1'b0;

        phase("idle", 7'h00, 4'hF, 10, 0, '0, '0, 0, 0);
        chk("idle_no_fd", fd_cnt, 0);

        base = fd_cnt;
        phase("d0", 7'h06, 4'hE, 10, 1, 16'h0001, 4'h1, 0, 0);
        phase("d1", 7'h5B, 4'hD, 10, 1, 16'h0021, 4'h3, 0, 0);
        phase("d2", 7'h4F, 4'hB, 10, 1, 16'h0321, 4'h7, 0, 0);
        phase("d3", 7'h66, 4'h7, 10, 1, 16'h4321, 4'hF, 0, 1);
        chk("frame_pulses", fd_cnt - base, 1);

        base = fd_cnt;
        phase("d0_5", 7'h6D, 4'hE, 10, 1, 16'h4325, 4'hF, 0, 0);
        phase("glitch1", 7'h06, 4'hE, 3, 0, '0, '0, 0, 0);
        phase("d0_0", 7'h3F, 4'hE, 10, 1, 16'h4320, 4'hF, 0, 0);
        phase("illegal", 7'h01, 4'hE, 10, 1, 16'h4320, 4'hE, 1, 0);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        chk("clr_err", err, 0);
        cur_err = 1'b0;

        phase("two_an", 7'h66, 4'hC, 10, 1, 16'h4320, 4'hE, 1, 0);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        chk("clr_err2", err, 0);
        cur_err = 1'b0;
        chk("no_fd_partial", fd_cnt - base, 0);

        phase("r0", 7'h07, 4'hE, 10, 1, 16'h4327, 4'hF, 0, 0);
        phase("r1", 7'h7F, 4'hD, 10, 1, 16'h4387, 4'hF, 0, 0);
        phase("r2", 7'h6F, 4'hB, 10, 1, 16'h4987, 4'hF, 0, 0);
        seg = ~7'h77;
        an  = 4'h7;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_digits", digits, 0);
        chk("arst_valid", digit_valid, 0);
        chk("arst_err", err, 0);
        chk("arst_fd", frame_done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur_dig = '0;
        cur_val = '0;
        cur_err = 1'b0;

        base = fd_cnt;
        phase("f3", 7'h71, 4'h7, 10, 1, 16'hF000, 4'h8, 0, 0);
        phase("f0", 7'h7C, 4'hE, 10, 1, 16'hF00B, 4'h9, 0, 0);
        phase("f1", 7'h39, 4'hD, 10, 1, 16'hF0CB, 4'hB, 0, 0);
        phase("f2", 7'h5E, 4'hB, 10, 1, 16'hFDCB, 4'hF, 0, 1);
        chk("refill_pulses", fd_cnt - base, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
